axi_bram2axis: RTL and testbench

BRAM-to-AXI4-Stream reader. It reads a contiguous BRAM region of programmed size starting at address 0 and emits it as an AXI4-Stream packet with `tlast` on the final beat. It sits downstream of the result BRAM and feeds the AXI write-master stream, mirroring the stream-to-BRAM loader on the input side. It absorbs the fixed BRAM read latency and downstream backpressure with a credit-controlled output FIFO.

---
 rtl/axi_bram2axis.sv | 159 +++++++++++++++
 tb/tb_axi_bram2axis.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_bram2axis.sv
// axi_bram2axis: reads BRAM words 0..depth-1 and emits them as one AXI4-Stream
// packet, tlast on the final beat. Reads are credit-limited against a small
// output FIFO, so the fixed BRAM latency and downstream stalls never lose data.
//
// Handshake: a beat transfers on a cycle where m_axis_tvalid && m_axis_tready.
// tvalid never drops and tdata/tlast never change while tvalid && !tready.
module axi_bram2axis #(
  parameter int AXI_DATA_WIDTH      = 128,
  parameter int AXI_XFER_SIZE_WIDTH = 32,
  parameter int BRAM_ADDR_WIDTH     = 32,
  parameter int BRAM_DATA_WIDTH     = 128,
  parameter int BRAM_DELAY          = 2,
  parameter int FIFO_DEPTH          = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_b2as_start,
  output logic                           o_b2as_done,
  input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_b2as_data_size_bytes,
  output logic                           o_b2as_rden,
  output logic [BRAM_ADDR_WIDTH-1:0]     o_b2as_rdaddr,
  input  logic [BRAM_DATA_WIDTH-1:0]     i_b2as_rddata,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [AXI_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                           m_axis_tlast,
  output logic [1:0]                     dbg_state
);

  localparam int XW = AXI_XFER_SIZE_WIDTH;
  localparam int AW = BRAM_ADDR_WIDTH;
  localparam int DW = BRAM_DATA_WIDTH;
  localparam int D  = BRAM_DELAY;
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam int IW = PW - 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t          state;
  logic [AW:0]     depth;
  logic [AW:0]     issued;
  logic [AW:0]     inflight;
  logic [AW-1:0]   rdaddr_q;
  logic [D-1:0]    sr_vld;
  logic [D-1:0]    sr_last;
  logic [DW:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [PW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_full;
  logic [DW:0]     fifo_head;
  logic [XW+2:0]   size_bits;
  logic [XW+2:0]   depth_words;
  logic [AW:0]     depth_calc;
  logic [AW+1:0]   occupancy;
  logic            credit_ok;
  logic            rd_fire;
  logic            tag_last;
  logic            push;
  logic            pop;

  // Byte count to whole BRAM words; a partial trailing word is dropped.
  assign size_bits   = {i_b2as_data_size_bytes, 3'b000};
  assign depth_words = size_bits / (XW+3)'(DW);
  assign depth_calc  = (AW+1)'(depth_words);

  // FIFO bookkeeping: pointers carry a wrap bit above the index.
  assign fifo_count = wptr - rptr;
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[IW] != rptr[IW]) && (wptr[IW-1:0] == rptr[IW-1:0]);
  assign fifo_head  = mem[rptr[IW-1:0]];

  // A read is only issued if its data is guaranteed a FIFO slot on arrival.
  assign occupancy = {1'b0, inflight} + (AW+2)'(fifo_count);
  assign credit_ok = occupancy < (AW+2)'(FIFO_DEPTH);
  assign rd_fire   = (state == S_READ) && (issued < depth) && credit_ok;
  assign tag_last  = ({1'b0, rdaddr_q} == (depth - (AW+1)'(1)));

  assign push = sr_vld[D-1];
  assign pop  = !fifo_empty && m_axis_tready;

  assign o_b2as_done   = (state == S_IDLE);
  assign o_b2as_rden   = rd_fire;
  assign o_b2as_rdaddr = rdaddr_q;
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_empty ? '0 : fifo_head[DW-1:0];
  assign m_axis_tlast  = !fifo_empty && fifo_head[DW];
  assign dbg_state     = state;

  // Control FSM: latch depth on start, walk read addresses, wait for the drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      depth    <= '0;
      issued   <= '0;
      rdaddr_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_b2as_start) begin
            depth    <= depth_calc;
            issued   <= '0;
            rdaddr_q <= '0;
            state    <= S_READ;
          end
        end
        S_READ: begin
          if (rd_fire) begin
            issued <= issued + (AW+1)'(1);
            // Hold the final address once the last read has gone out.
            if ((issued + (AW+1)'(1)) < depth) rdaddr_q <= rdaddr_q + AW'(1);
          end
          if ((issued + (AW+1)'(rd_fire)) >= depth) state <= S_DRAIN;
        end
        S_DRAIN: begin
          // Leave as the last buffered beat is accepted so done follows it directly.
          if (inflight == '0 && (fifo_empty || (fifo_count == PW'(1) && pop)))
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read tags travel alongside the BRAM latency; in-flight count feeds the credit check.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_vld   <= '0;
      sr_last  <= '0;
      inflight <= '0;
    end else begin
      sr_vld[0]  <= rd_fire;
      sr_last[0] <= rd_fire && tag_last;
      for (int i = 1; i < D; i++) begin
        sr_vld[i]  <= sr_vld[i-1];
        sr_last[i] <= sr_last[i-1];
      end
      inflight <= inflight + (AW+1)'(rd_fire) - (AW+1)'(push);
    end
  end

  // FIFO pointers; push and pop may coincide at any occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // FIFO storage: arriving BRAM word with its last tag.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[IW-1:0]] <= {sr_last[D-1], i_b2as_rddata};
  end

endmodule

// File: tb/tb_axi_bram2axis.sv
// Bench for axi_bram2axis: BRAM model with fixed latency, tready driver,
// scoreboard of expected {tlast,tdata} beats and an address sequence monitor.
module tb_axi_bram2axis;

  localparam int DW = 128;
  localparam int AW = 32;
  localparam int XW = 32;
  localparam int D  = 2;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          done;
  logic [XW-1:0] size_bytes;
  logic          rden;
  logic [AW-1:0] rdaddr;
  logic [DW-1:0] rddata;
  logic          tvalid;
  logic          tready;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];
  int exp_addr = 0;
  int ready_mode = 0;
  int rel_cyc = 0;
  logic prev_stall = 1'b0;
  logic [DW:0] prev_beat;
  logic [DW-1:0] bram [64];
  logic [DW-1:0] rd_pipe [D];

  // clock / reset block
  always #5 clk = ~clk;

  axi_bram2axis #(
    .AXI_DATA_WIDTH(DW), .AXI_XFER_SIZE_WIDTH(XW), .BRAM_ADDR_WIDTH(AW),
    .BRAM_DATA_WIDTH(DW), .BRAM_DELAY(D), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .i_b2as_start(start), .o_b2as_done(done),
    .i_b2as_data_size_bytes(size_bytes), .o_b2as_rden(rden),
    .o_b2as_rdaddr(rdaddr), .i_b2as_rddata(rddata),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .m_axis_tlast(tlast), .dbg_state(dbg_state)
  );

  // BRAM model: data appears D cycles after rden, junk otherwise.
  always @(posedge clk) begin
    rd_pipe[0] <= rden ? bram[rdaddr[5:0]] : {$urandom, $urandom, $urandom, $urandom};
    for (int i = 1; i < D; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rddata = rd_pipe[D-1];

  // tready driver: 0 always ready, 1 random, 2 stalled in cycles 5..14.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       tready = 1'b1;
      1:       tready = ($urandom_range(0, 3) != 0);
      default: tready = !(rel_cyc >= 5 && rel_cyc <= 14);
    endcase
  end

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: read address order, stall stability, scoreboard pop on each accepted beat.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      logic [DW:0] e;
      if (rden) begin
        chk("rdaddr", {97'd0, rdaddr}, exp_addr);
        exp_addr++;
      end
      if (tvalid && prev_stall) chk("stall_hold", {tlast, tdata}, prev_beat);
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h required=none", {tlast, tdata});
        end else begin
          e = exp_q.pop_front();
          chk("beat", {tlast, tdata}, e);
        end
      end
      prev_stall = tvalid && !tready;
      prev_beat  = {tlast, tdata};
    end
  end

  // Reference model: depth whole words, word i of a fresh BRAM image, tlast on the final one.
  task automatic load_packet(input int size, input bit seq);
    int depth;
    depth = size * 8 / DW;
    for (int i = 0; i < 64; i++)
      bram[i] = seq ? DW'(i) : {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < depth; i++) exp_q.push_back({(i == depth - 1), bram[i]});
    exp_addr = 0;
  endtask

  // Driver: start a packet and observe it until done returns (bounded).
  task automatic run_packet(input int size, input bit seq, input bit inject,
                            output int first_rd, output int first_vld, output int done_at,
                            output int nrd, output int nbeat, output int max_out);
    first_rd = -1; first_vld = -1; done_at = -1;
    nrd = 0; nbeat = 0; max_out = 0;
    load_packet(size, seq);
    @(posedge clk); #1;
    start = 1'b1;
    size_bytes = XW'(size);
    rel_cyc = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rel_cyc > 0 && done) begin
        done_at = rel_cyc;
        break;
      end
      if (rden) begin
        nrd++;
        if (first_rd < 0) first_rd = rel_cyc;
      end
      if (tvalid && first_vld < 0) first_vld = rel_cyc;
      if (tvalid && tready) nbeat++;
      if (nrd - nbeat > max_out) max_out = nrd - nbeat;
      @(posedge clk); #1;
      start = 1'b0;
      if (inject && rel_cyc + 1 == 2) begin
        start = 1'b1;
        size_bytes = XW'(256);
      end
      rel_cyc++;
    end
    if (done_at < 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int frd, fvld, dat, nrd, nbeat, mout, depth, idle_bad;
    rst = 1'b1; start = 1'b0; size_bytes = '0; tready = 1'b1; ready_mode = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_done", done, 1);
    chk("rst_rden", rden, 0);
    chk("rst_rdaddr", rdaddr, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);

    // depth 4, continuously ready
    run_packet(64, 1'b1, 1'b0, frd, fvld, dat, nrd, nbeat, mout);
    chk("d4_first_rden", frd, 1);
    chk("d4_first_valid", fvld, 4);
    chk("d4_done", dat, 8);
    chk("d4_reads", nrd, 4);
    chk("d4_beats", nbeat, 4);
    chk("d4_leftover", exp_q.size(), 0);

    // depth 16 with a backpressure window
    ready_mode = 2;
    run_packet(256, 1'b1, 1'b0, frd, fvld, dat, nrd, nbeat, mout);
    chk("d16_reads", nrd, 16);
    chk("d16_beats", nbeat, 16);
    chk("d16_credit", (mout <= FD), 1);
    chk("d16_leftover", exp_q.size(), 0);
    ready_mode = 0;

    // empty packet
    run_packet(0, 1'b1, 1'b0, frd, fvld, dat, nrd, nbeat, mout);
    chk("d0_reads", nrd, 0);
    chk("d0_valid", fvld, -1);
    chk("d0_done", dat, 3);

    // 40 bytes truncates to 2 words
    run_packet(40, 1'b0, 1'b0, frd, fvld, dat, nrd, nbeat, mout);
    chk("d2_reads", nrd, 2);
    chk("d2_beats", nbeat, 2);
    chk("d2_done", dat, 6);

    // start pulse during READ is ignored
    run_packet(64, 1'b0, 1'b1, frd, fvld, dat, nrd, nbeat, mout);
    chk("inj_beats", nbeat, 4);
    chk("inj_done", dat, 8);
    idle_bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (tvalid || rden || !done) idle_bad++;
    end
    chk("inj_idle", idle_bad, 0);

    // reset while beat 5 of 16 is presented
    load_packet(256, 1'b0);
    @(posedge clk); #1;
    start = 1'b1;
    size_bytes = XW'(256);
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("mid_beats_before_rst", 16 - exp_q.size(), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_rden", rden, 0);
    chk("mid_rst_done", done, 1);
    exp_q.delete();
    run_packet(48, 1'b0, 1'b0, frd, fvld, dat, nrd, nbeat, mout);
    chk("post_rst_beats", nbeat, 3);
    chk("post_rst_reads", nrd, 3);
    chk("post_rst_done", dat, 7);
    chk("post_rst_leftover", exp_q.size(), 0);

    // randomized sizes with random backpressure
    ready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      int sz;
      sz = $urandom_range(0, 511);
      depth = sz * 8 / DW;
      run_packet(sz, 1'b0, 1'b0, frd, fvld, dat, nrd, nbeat, mout);
      chk("rnd_reads", nrd, depth);
      chk("rnd_beats", nbeat, depth);
      chk("rnd_credit", (mout <= FD), 1);
      chk("rnd_leftover", exp_q.size(), 0);
    end
    ready_mode = 0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
